// File: rtl/ifft_ctrl_pkg.sv
// rtl/ifft_ctrl_pkg.sv - shared types and offset arithmetic for the SDF IFFT frame controller
//
// Contents:
//   state_t            controller state encoding (IDLE=0, LOAD=1, DRAIN=2)
//   stage_off(s, ...)  timeline offset at which stage s (1-based) starts its twiddle walk
//   total_lat(...)     timeline value of the first valid pipeline output sample
package ifft_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Stage s sees its first sample once all earlier delay lines (N/2, N/4, ...)
   // are full, plus the extra register latency of every stage in front of it.
   function automatic int stage_off(input int s, input int nfft, input int stage_lat);
      return (nfft - (nfft >> (s - 1))) + (s - 1) * stage_lat;
   endfunction

   function automatic int total_lat(input int nfft, input int stage_lat);
      return (nfft - 1) + $clog2(nfft) * stage_lat;
   endfunction

endpackage

// File: rtl/ifft_stage_start_dec.sv
// rtl/ifft_stage_start_dec.sv - per-stage twiddle-activation pulse decoder
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   active_next       controller will be in LOAD or DRAIN next cycle
//   t_next            timeline counter value for next cycle
//   first             first sample of a frame is being accepted this cycle
//   stage_start       bit s-1 pulses for one cycle at timeline value OFF(s)
module ifft_stage_start_dec
   import ifft_ctrl_pkg::*;
#(
   parameter int NFFT      = 128,
   parameter int STAGE_LAT = 1,
   parameter int LOG2N     = 7,
   parameter int TW        = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             active_next,
   input  logic [TW-1:0]    t_next,
   input  logic             first,
   output logic [LOG2N-1:0] stage_start
);

   for (genvar s = 0; s < LOG2N; s++) begin : g_stage
      localparam int OFF = stage_off(s + 1, NFFT, STAGE_LAT);
      if (OFF == 0) begin : g_first
         // Offset zero coincides with the accepting cycle itself, which cannot
         // be known a cycle early, so this bit follows the acceptance directly.
         assign stage_start[s] = first;
      end else begin : g_reg
         logic pulse;
         // Compare against next cycle's timeline so the registered pulse lands
         // exactly in the cycle whose timeline value equals the offset.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               pulse <= 1'b0;
            end else begin
               pulse <= active_next && (t_next == TW'(OFF));
            end
         end
         assign stage_start[s] = pulse;
      end
   end

endmodule

// File: rtl/ifft_sdf_frame_ctrl.sv
// rtl/ifft_sdf_frame_ctrl.sv - frame sequencer for the SDF IFFT stage chain
//
// Optional feature macro: IFFT_FRAME_CNT_EN (adds 16-bit frame_count output)
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   frame_count     completed-frame counter (only with IFFT_FRAME_CNT_EN)
//   in_valid        input sample present
//   in_ready        controller accepts samples (IDLE or LOAD)
//   stage_start     one-cycle twiddle-activation pulse per stage
//   pipe_busy       frame in flight (LOAD or DRAIN)
//   out_valid       pipeline output sample valid
//   frame_done      pulse on the last valid output sample
//   err_underrun    pulse the cycle after in_valid dropped during LOAD
//
// Timeline: the cycle accepting the first sample is t=0; the counter holds
// the cycle index from then on. All pulse outputs are registered from the
// next-cycle state/counter so they align with the timeline value they name.
module ifft_sdf_frame_ctrl
   import ifft_ctrl_pkg::*;
#(
   parameter int   NFFT      = 128,
   parameter int   STAGE_LAT = 1,
   localparam int  LOG2N     = $clog2(NFFT)
) (
   input  logic             clk,
   input  logic             rst,
`ifdef IFFT_FRAME_CNT_EN
   output logic [15:0]      frame_count,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   output logic [LOG2N-1:0] stage_start,
   output logic             pipe_busy,
   output logic             out_valid,
   output logic             frame_done,
   output logic             err_underrun
);

   localparam int TOTAL_LAT = total_lat(NFFT, STAGE_LAT);
   localparam int LAST_T    = TOTAL_LAT + NFFT - 1;
   localparam int TW        = $clog2(TOTAL_LAT + NFFT) + 1;

   state_t          state;
   state_t          state_nxt;
   logic [TW-1:0]   t;
   logic [TW-1:0]   t_nxt;
   logic            underrun_nxt;
   logic            active_nxt;
   logic            ov_nxt;
   logic            fd_nxt;
   logic            first;

   assign in_ready  = (state != DRAIN);
   assign pipe_busy = (state != IDLE);
   // Gated by rst so no pulse escapes while reset is held.
   assign first     = rst && (state == IDLE) && in_valid;

   always_comb begin
      state_nxt    = state;
      t_nxt        = t;
      underrun_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = LOAD;
               t_nxt     = TW'(1);
            end else begin
               t_nxt     = '0;
            end
         end
         LOAD: begin
            if (!in_valid) begin
               state_nxt    = IDLE;
               t_nxt        = '0;
               underrun_nxt = 1'b1;
            end else begin
               t_nxt = t + TW'(1);
               if (t == TW'(NFFT - 1)) begin
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (t == TW'(LAST_T)) begin
               state_nxt = IDLE;
               t_nxt     = '0;
            end else begin
               t_nxt = t + TW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            t_nxt     = '0;
         end
      endcase
      active_nxt = (state_nxt != IDLE);
      ov_nxt     = active_nxt && (t_nxt >= TW'(TOTAL_LAT)) && (t_nxt <= TW'(LAST_T));
      fd_nxt     = active_nxt && (t_nxt == TW'(LAST_T));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         t            <= '0;
         out_valid    <= 1'b0;
         frame_done   <= 1'b0;
         err_underrun <= 1'b0;
      end else begin
         state        <= state_nxt;
         t            <= t_nxt;
         out_valid    <= ov_nxt;
         frame_done   <= fd_nxt;
         err_underrun <= underrun_nxt;
      end
   end

`ifdef IFFT_FRAME_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_count <= '0;
      end else if (fd_nxt) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`endif

   ifft_stage_start_dec #(
      .NFFT      (NFFT),
      .STAGE_LAT (STAGE_LAT),
      .LOG2N     (LOG2N),
      .TW        (TW)
   ) u_dec (
      .clk         (clk),
      .rst         (rst),
      .active_next (active_nxt),
      .t_next      (t_nxt),
      .first       (first),
      .stage_start (stage_start)
   );

endmodule

// File: tb/tb_ifft_sdf_frame_ctrl.sv
// tb/tb_ifft_sdf_frame_ctrl.sv - scoreboard bench for ifft_sdf_frame_ctrl (128/1 and 16/0 configs)
module tb_ifft_sdf_frame_ctrl;

   logic       clk;
   logic       rst;
   logic [1:0] in_valid;
   logic [1:0] exp_busy;
   logic [1:0] exp_ready;

   logic       rdy0, busy0, ov0, fd0, err0;
   logic [6:0] ss0;
   logic       rdy1, busy1, ov1, fd1, err1;
   logic [3:0] ss1;
`ifdef IFFT_FRAME_CNT_EN
   logic [15:0] fc0, fc1;
`endif

   ifft_sdf_frame_ctrl #(.NFFT(128), .STAGE_LAT(1)) dut0 (
      .clk          (clk),
      .rst          (rst),
`ifdef IFFT_FRAME_CNT_EN
      .frame_count  (fc0),
`endif
      .in_valid     (in_valid[0]),
      .in_ready     (rdy0),
      .stage_start  (ss0),
      .pipe_busy    (busy0),
      .out_valid    (ov0),
      .frame_done   (fd0),
      .err_underrun (err0)
   );

   ifft_sdf_frame_ctrl #(.NFFT(16), .STAGE_LAT(0)) dut1 (
      .clk          (clk),
      .rst          (rst),
`ifdef IFFT_FRAME_CNT_EN
      .frame_count  (fc1),
`endif
      .in_valid     (in_valid[1]),
      .in_ready     (rdy1),
      .stage_start  (ss1),
      .pipe_busy    (busy1),
      .out_valid    (ov1),
      .frame_done   (fd1),
      .err_underrun (err1)
   );

   typedef struct {
      int cyc;
      int stage;
      bit ov;
      bit fd;
      bit err;
   } ev_t;

   ev_t q0[$];
   ev_t q1[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  nfft[2];
   int  slat[2];
   int  lg[2];
   int  tl[2];
   int  endt[2];
   int  good[2];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int off(input int i, input int s);
      return nfft[i] - (nfft[i] >> (s - 1)) + (s - 1) * slat[i];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int i, input ev_t e);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic ev_t qfront(input int i);
      if (i == 0) return q0[0];
      return q1[0];
   endfunction

   task automatic qpop(input int i);
      if (i == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
   endtask

   // Expected output events for a frame whose first sample is accepted at c0.
   task automatic gen_frame(input int i, input int c0, input int drop);
      int last;
      ev_t e;
      last = (drop > 0) ? drop : endt[i];
      for (int k = 0; k <= last; k++) begin
         e.cyc   = c0 + k;
         e.stage = 0;
         for (int s = 1; s <= lg[i]; s++)
            if (off(i, s) == k) e.stage = e.stage | (1 << (s - 1));
         e.ov  = (k >= tl[i]) && (k <= endt[i]);
         e.fd  = (k == endt[i]);
         e.err = 1'b0;
         if (e.stage != 0 || e.ov || e.fd) push(i, e);
      end
      if (drop > 0) begin
         e.cyc = c0 + drop + 1; e.stage = 0; e.ov = 0; e.fd = 0; e.err = 1;
         push(i, e);
      end
   endtask

   task automatic mon(input int i, input int ss, input bit ov, input bit fd, input bit err,
                      input bit rdy, input bit busy);
      ev_t e;
      chk($sformatf("i%0d_in_ready", i), 32'(rdy), 32'(exp_ready[i]));
      chk($sformatf("i%0d_pipe_busy", i), 32'(busy), 32'(exp_busy[i]));
      while (qsize(i) > 0 && qfront(i).cyc < cyc) begin
         chk($sformatf("i%0d_missed_event_cycle", i), 32'(cyc), 32'(qfront(i).cyc));
         qpop(i);
      end
      if (ss != 0 || ov || fd || err) begin
         if (qsize(i) == 0) begin
            chk($sformatf("i%0d_unexpected_output", i), 32'({ss[15:0], ov, fd, err}), 32'd0);
         end else begin
            e = qfront(i);
            qpop(i);
            chk($sformatf("i%0d_event_cycle", i), 32'(cyc), 32'(e.cyc));
            chk($sformatf("i%0d_stage_start", i), 32'(ss), 32'(e.stage));
            chk($sformatf("i%0d_out_valid", i), 32'(ov), 32'(e.ov));
            chk($sformatf("i%0d_frame_done", i), 32'(fd), 32'(e.fd));
            chk($sformatf("i%0d_err_underrun", i), 32'(err), 32'(e.err));
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         mon(0, int'(ss0), ov0, fd0, err0, rdy0, busy0);
         mon(1, int'(ss1), ov1, fd1, err1, rdy1, busy1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int i, input int n);
      repeat (n) begin
         in_valid[i]  = 1'b0;
         exp_busy[i]  = 1'b0;
         exp_ready[i] = 1'b1;
         step();
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_stage0", 32'(ss0), 0);
      chk("rst_ov0", 32'(ov0), 0);
      chk("rst_fd0", 32'(fd0), 0);
      chk("rst_err0", 32'(err0), 0);
      chk("rst_ready0", 32'(rdy0), 1);
      chk("rst_busy0", 32'(busy0), 0);
      chk("rst_stage1", 32'(ss1), 0);
      chk("rst_ov1", 32'(ov1), 0);
      chk("rst_fd1", 32'(fd1), 0);
      chk("rst_err1", 32'(err1), 0);
      chk("rst_ready1", 32'(rdy1), 1);
      chk("rst_busy1", 32'(busy1), 0);
   endtask

   // gap idle cycles, then a frame; drop>0 aborts at that sample index,
   // hold keeps in_valid high through drain, rst_at>=0 resets at that index.
   task automatic frame(input int i, input int gap, input int drop, input bit hold, input int rst_at);
      int c0;
      int last;
      idle(i, gap);
      c0 = cyc;
      gen_frame(i, c0, drop);
      last = (drop > 0) ? drop : endt[i];
      for (int k = 0; k <= last; k++) begin
         if (k == rst_at) begin
            in_valid[i] = 1'b0;
            rst = 1'b0;
            #1;
            check_reset_outputs();
            q0.delete();
            q1.delete();
            good[0] = 0;
            good[1] = 0;
            exp_busy[i]  = 1'b0;
            exp_ready[i] = 1'b1;
            step();
            step();
            rst = 1'b1;
            return;
         end
         if (k < nfft[i]) in_valid[i] = !(drop > 0 && k == drop);
         else             in_valid[i] = hold ? 1'b1 : 1'($urandom_range(0, 1));
         exp_busy[i]  = (k >= 1);
         exp_ready[i] = (k < nfft[i]);
         step();
      end
      if (drop == 0) good[i]++;
      else           idle(i, 1);
      in_valid[i]  = 1'b0;
      exp_busy[i]  = 1'b0;
      exp_ready[i] = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      in_valid = 2'b00;
      exp_busy = 2'b00;
      exp_ready = 2'b11;
      nfft[0] = 128; slat[0] = 1;
      nfft[1] = 16;  slat[1] = 0;
      for (int i = 0; i < 2; i++) begin
         lg[i]   = $clog2(nfft[i]);
         tl[i]   = nfft[i] - 1 + lg[i] * slat[i];
         endt[i] = tl[i] + nfft[i] - 1;
         good[i] = 0;
      end
      #3;
      check_reset_outputs();
      step();
      step();
      rst = 1'b1;

      frame(0, 2, 0, 1'b0, -1);
      frame(0, 1, 50, 1'b0, -1);
      frame(0, 2, 0, 1'b1, -1);
      frame(0, 0, 0, 1'b1, -1);
      frame(0, 0, 0, 1'b0, -1);
      frame(0, 3, 0, 1'b0, 140);
      for (int n = 0; n < 5; n++)
         frame(0, $urandom_range(0, 3),
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 127) : 0,
               1'($urandom_range(0, 1)), -1);

      frame(1, 2, 0, 1'b0, -1);
      frame(1, 1, 15, 1'b0, -1);
      frame(1, 1, 8, 1'b0, -1);
      frame(1, 0, 0, 1'b1, -1);
      frame(1, 0, 0, 1'b0, -1);
      for (int n = 0; n < 12; n++)
         frame(1, $urandom_range(0, 3),
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0,
               1'($urandom_range(0, 1)), -1);

      idle(0, 2);
      idle(1, 2);
      chk("i0_queue_empty", 32'(q0.size()), 0);
      chk("i1_queue_empty", 32'(q1.size()), 0);
`ifdef IFFT_FRAME_CNT_EN
      chk("i0_frame_count", 32'(fc0), 32'(good[0]));
      chk("i1_frame_count", 32'(fc1), 32'(good[1]));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
